// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity codes and frame-size helper
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Serial bit count of one frame, start and stop bits included.
  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, one tick in the last clk of each serial bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  // Held at zero while disabled so every frame starts on a full bit period.
  always_ff @(posedge clk) begin
    if (!rst_n || !en || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] txd_data,
  input  logic              txd_start,
  output logic              txd,
  output logic              busy,
  output logic              txd_done
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  generate
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_tx_frame: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     bit_idx;
  logic              stop_cnt;
  logic              par_bit;
  logic              bit_tick;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (busy),
    .bit_tick (bit_tick)
  );

  assign busy     = (state != TX_IDLE);
  assign txd_done = (state == TX_STOP) && bit_tick && (stop_cnt == LAST_STOP);

  // txd is always loaded one edge ahead so the line comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      txd      <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (txd_start) begin
            shreg    <= txd_data;
            par_bit  <= (PARITY == PAR_ODD) ? ~^txd_data : ^txd_data;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            txd      <= 1'b0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (bit_tick) begin
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
              if (PARITY != PAR_NONE) begin
                txd   <= par_bit;
                state <= TX_PARITY;
              end else begin
                txd   <= 1'b1;
                state <= TX_STOP;
              end
            end else begin
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        TX_PARITY: begin
          if (bit_tick) begin
            txd   <= 1'b1;
            state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (bit_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state <= TX_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= TX_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
